// File: rtl/enemy_bullet_gen.sv
// -----------------------------------------------------------------------------
// enemy_bullet_gen
//
// Drives the single enemy bullet. After a cooldown of FIRE_INTERVAL game ticks,
// a bullet spawns below the enemy plane. It then falls SPEED pixels per tick
// until it reaches Y_LIMIT or the player-hit judge consumes it. The outputs
// feed the judge's bullet position and enable inputs directly.
//
// Optional build macro:
//   AIMED_SHOT_EN - while in flight, each movement tick also steps eb_x by one
//                   pixel toward p_x+SPAWN_DX. The step saturates at 0/1023.
//                   Without the macro, eb_x stays constant during flight and
//                   p_x is unused.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   tick      in   one-cycle game-step strobe
//   enemy_en  in   enemy plane alive
//   e_x, e_y  in   enemy position (10 bit)
//   p_x       in   player x (10 bit), used only with AIMED_SHOT_EN
//   hit       in   one-cycle pulse from the judge: bullet consumed
//   freeze    in   game over / pause; every register holds
//   eb_x,eb_y out  bullet position (10 bit), registered
//   eb_en     out  bullet live, registered
//   shots     out  bullets fired, 8 bit, wraps
// -----------------------------------------------------------------------------
module enemy_bullet_gen #(
    parameter int FIRE_INTERVAL = 8,
    parameter int SPEED         = 4,
    parameter int SPAWN_DX      = 20,
    parameter int SPAWN_DY      = 520,
    parameter int Y_LIMIT       = 960
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       enemy_en,
    input  logic [9:0] e_x,
    input  logic [9:0] e_y,
    input  logic [9:0] p_x,
    input  logic       hit,
    input  logic       freeze,
    output logic [9:0] eb_x,
    output logic [9:0] eb_y,
    output logic       eb_en,
    output logic [7:0] shots
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COOL = 2'd1,
        FLY  = 2'd2
    } state_t;

    localparam logic [7:0]  CD_RELOAD = 8'(FIRE_INTERVAL - 1);
    localparam logic [9:0]  DX10      = 10'(SPAWN_DX);
    localparam logic [9:0]  DY10      = 10'(SPAWN_DY);
    localparam logic [10:0] SPD11     = 11'(SPEED);
    localparam logic [10:0] YLIM11    = 11'(Y_LIMIT);

    state_t      state, state_nxt;
    logic [7:0]  cd, cd_nxt;
    logic [9:0]  eb_x_nxt, eb_y_nxt;
    logic        eb_en_nxt;
    logic [7:0]  shots_nxt;

    // Spawn point wraps naturally at 10 bits.
    logic [9:0]  spawn_x, spawn_y;
    // The fall is computed one bit wider so the carry takes part in the limit
    // compare and the bullet can never wrap back to the top of the field.
    logic [10:0] ny;

    assign spawn_x = e_x + DX10;
    assign spawn_y = e_y + DY10;
    assign ny      = {1'b0, eb_y} + SPD11;

`ifdef AIMED_SHOT_EN
    logic [10:0] aim_tgt;
    assign aim_tgt = {1'b0, p_x} + 11'(SPAWN_DX);

    // One-pixel step toward the target. The step saturates at the ends of the
    // 10-bit range, because the target can lie beyond 1023.
    function automatic logic [9:0] step_toward(input logic [9:0]  x,
                                               input logic [10:0] tgt);
        logic [9:0] r;
        r = x;
        if ({1'b0, x} < tgt) begin
            if (x != 10'h3FF) r = x + 10'd1;
        end else if ({1'b0, x} > tgt) begin
            if (x != 10'h000) r = x - 10'd1;
        end
        return r;
    endfunction
`else
    logic unused_p_x;
    assign unused_p_x = ^p_x;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cd    <= 8'd0;
            eb_x  <= 10'd0;
            eb_y  <= 10'd0;
            eb_en <= 1'b0;
            shots <= 8'd0;
        end else begin
            state <= state_nxt;
            cd    <= cd_nxt;
            eb_x  <= eb_x_nxt;
            eb_y  <= eb_y_nxt;
            eb_en <= eb_en_nxt;
            shots <= shots_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cd_nxt    = cd;
        eb_x_nxt  = eb_x;
        eb_y_nxt  = eb_y;
        eb_en_nxt = eb_en;
        shots_nxt = shots;

        if (!freeze) begin
            case (state)
                IDLE: begin
                    eb_en_nxt = 1'b0;
                    if (enemy_en) begin
                        cd_nxt    = CD_RELOAD;
                        state_nxt = COOL;
                    end
                end

                COOL: begin
                    eb_en_nxt = 1'b0;
                    if (!enemy_en) begin
                        state_nxt = IDLE;
                    end else if (tick) begin
                        if (cd != 8'd0) begin
                            cd_nxt = cd - 8'd1;
                        end else begin
                            eb_x_nxt  = spawn_x;
                            eb_y_nxt  = spawn_y;
                            eb_en_nxt = 1'b1;
                            shots_nxt = shots + 8'd1;
                            state_nxt = FLY;
                        end
                    end
                end

                FLY: begin
                    // The enemy may have died mid-flight. enemy_en matters only
                    // when the bullet retires. A hit overrides a same-cycle
                    // tick, and the position holds where the hit occurred.
                    if (hit || (tick && (ny >= YLIM11))) begin
                        eb_en_nxt = 1'b0;
                        cd_nxt    = CD_RELOAD;
                        state_nxt = enemy_en ? COOL : IDLE;
                    end else if (tick) begin
                        eb_y_nxt = ny[9:0];
`ifdef AIMED_SHOT_EN
                        eb_x_nxt = step_toward(eb_x, aim_tgt);
`endif
                    end
                end

                default: begin
                    eb_en_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/enemy_bullet_gen.md
Name: enemy_bullet_gen

Overview:
- Upstream producer of the single enemy bullet consumed by the player-hit judge.
- Spawns a bullet under the enemy plane after a cooldown and moves it down the playfield once per game tick.
- Retires the bullet when it leaves the field or when the judge reports a hit.
- Outputs eb_x / eb_y / eb_en drive the judge's bullet position and bullet-enable inputs directly.

Parameters:
- FIRE_INTERVAL, 8: ticks spent in cooldown before a shot (1..255).
- SPEED, 4: pixels added to eb_y per tick.
- SPAWN_DX, 20: x offset from e_x to the bullet spawn point.
- SPAWN_DY, 520: y offset from e_y to the spawn point (judge y-space is screen y + 480).
- Y_LIMIT, 960: bullet retires when eb_y reaches or exceeds this value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle game-step strobe
- enemy_en  in  1  enemy plane alive
- e_x  in  10  enemy x
- e_y  in  10  enemy y
- p_x  in  10  player x (used only with AIMED_SHOT_EN)
- hit  in  1  one-cycle pulse from the judge: bullet consumed
- freeze  in  1  game over / pause; hold all state
- eb_x  out  10  bullet x
- eb_y  out  10  bullet y
- eb_en  out  1  bullet live
- shots  out  8  count of bullets fired, wraps at 255->0

Behaviour:
- Reset (async): state=IDLE, eb_x=0, eb_y=0, eb_en=0, shots=0, cooldown counter cd=0.
- All outputs are registered; there is no combinational path from any input to any output.
- freeze=1: every register holds, including the state; tick and hit are ignored; freeze has top priority after rst.
- IDLE: eb_en=0.
  - If enemy_en=1: cd<=FIRE_INTERVAL-1, go to COOL on the next clk, regardless of tick.
- COOL: eb_en=0.
  - enemy_en=0: go to IDLE.
  - Otherwise on tick with cd!=0: cd<=cd-1.
  - Otherwise on tick with cd==0: spawn, then go to FLY.
- Spawn:
  - eb_x<=e_x+SPAWN_DX and eb_y<=e_y+SPAWN_DY, both truncated to 10 bits.
  - eb_en<=1, shots<=shots+1.
  - First fire tick count: exactly FIRE_INTERVAL ticks after entering COOL.
- FLY: eb_en=1.
  - hit=1: eb_en<=0, cd<=FIRE_INTERVAL-1, go to COOL (or to IDLE if enemy_en=0). eb_x/eb_y hold their last values.
  - Otherwise on tick: compute 11-bit ny=eb_y+SPEED.
    - ny>=Y_LIMIT: retire exactly as for hit.
    - Otherwise: eb_y<=ny[9:0].
  - hit and tick in the same cycle: hit wins; no movement that cycle.
  - enemy_en falling during FLY: the bullet keeps flying; enemy_en is checked only at retire.
- Arithmetic: sums are computed 11 bits wide and the overflow bit is used for the Y_LIMIT compare, so no wrap-around during flight.
- Between ticks, eb_x/eb_y are stable, which guarantees the judge sees a consistent coordinate pair.
- hit while not in FLY: ignored.
- Reset asserted mid-flight: the bullet vanishes immediately (eb_en=0 asynchronously).

Optional Feature:
- Macro AIMED_SHOT_EN.
- When defined: in FLY, on each movement tick, eb_x additionally steps by 1 toward p_x+SPAWN_DX.
  - eb_x < target: +1.
  - eb_x > target: -1.
  - equal: hold.
  - Saturates at 0 and 1023.
- When not defined: eb_x is constant during flight and p_x is unused.

Test Plan:
- Reset, enemy_en=1, e_x=100, e_y=50, 8 ticks -> eb_en rises after the 8th tick with eb_x=120, eb_y=570, shots=1.
- From eb_y=570, apply ticks -> eb_y increments 574, 578, ...; after the tick where 570+4k>=960 (k=98), eb_en=0, state=COOL, cd=7.
- hit pulse at eb_y=600 coincident with tick -> eb_en=0 the next cycle, eb_y holds 600, next shot fires 8 ticks later.
- enemy_en dropped mid-flight -> bullet continues to retire; afterwards IDLE with eb_en=0; no further shots while enemy_en=0.
- freeze=1 for 20 cycles with ticks in FLY -> eb_x, eb_y, eb_en and shots unchanged; motion resumes after release.
- AIMED_SHOT_EN defined, spawn eb_x=120, p_x=50 -> eb_x becomes 119, 118, ... one per tick, stopping at 70.
